// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared types and helpers for the gate truth-table sequencer
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    // Largest supported gate width; tables are zero-extended to this size
    localparam int MAX_N_IN = 6;
    localparam int MAX_VECS = 1 << MAX_N_IN;

    // Expected gate output for input combination vec
    function automatic logic exp_bit(input logic [MAX_VECS-1:0] tbl,
                                     input logic [MAX_N_IN-1:0] vec);
        return tbl[vec];
    endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// rtl/gate_truth_sequencer_if.sv - control, gate drive and result bundle of the sequencer
interface gate_truth_sequencer_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            gate_out;
    logic [N_IN-1:0] gate_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail_vec;

    // Controller side: issues start and closes the loop through the gate
    modport master (
        output start,
        output gate_out,
        input  gate_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  first_fail_vec
    );

    // Sequencer side
    modport slave (
        input  start,
        input  gate_out,
        output gate_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output first_fail_vec
    );
endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - one-shot down-counter marking the end of the settle window
module settle_timer #(
    parameter int CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);
    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [W-1:0] RELOAD = W'(CYC - 1);

    logic [W-1:0] cnt_q;
    logic         active_q;

    // Count down from CYC-1 after load; disarm once the zero cycle has been flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= RELOAD;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// rtl/gate_truth_sequencer.sv - walks a gate through all input combinations and checks its truth table
module gate_truth_sequencer
    import gate_test_pkg::*;
#(
    parameter int                     N_IN       = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED   = 4'b1110,
    parameter int                     SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_sequencer_if.slave bus
);
    localparam int                    NVEC     = 1 << N_IN;
    localparam logic [N_IN-1:0]       LAST_VEC = N_IN'(NVEC - 1);
    localparam logic [N_IN-1:0]       ONE_VEC  = N_IN'(1);
    localparam logic [N_IN:0]         ONE_ERR  = (N_IN+1)'(1);
    localparam logic [MAX_VECS-1:0]   EXP_TBL  = MAX_VECS'(EXPECTED);

    if (SETTLE_CYC < 1 || N_IN < 1 || N_IN > MAX_N_IN) begin : g_param_check
        $error("gate_truth_sequencer: SETTLE_CYC must be >=1 and N_IN within 1..6");
    end

    seq_state_t      state_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] gate_in_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_q;
    logic            fail_valid_q;
    logic [N_IN-1:0] first_fail_q;

    logic            start_ok;
    logic            last_vec;
    logic            timer_load;
    logic            expire;
    logic            exp_now;
    logic            mismatch;
    logic [N_IN:0]   err_d;

    // Start is only honoured when no run is in flight
    always_comb begin
        start_ok   = bus.start && (state_q == IDLE || state_q == DONE);
        last_vec   = (vec_q == LAST_VEC);
        timer_load = start_ok || (state_q == SAMPLE && !last_vec);
        exp_now    = exp_bit(EXP_TBL, MAX_N_IN'(vec_q));
        // Anything other than a clean 0/1 matching the table is a mismatch, X/Z included
        mismatch   = exp_now ? (bus.gate_out !== 1'b1) : (bus.gate_out !== 1'b0);
        err_d      = mismatch ? (err_q + ONE_ERR) : err_q;
    end

    settle_timer #(
        .CYC(SETTLE_CYC)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .expire(expire)
    );

    // Run sequencing, vector stepping and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            gate_in_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q      <= SETTLE;
                        vec_q        <= '0;
                        gate_in_q    <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                    end
                end
                SETTLE: begin
                    if (expire) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch && !fail_valid_q) begin
                        first_fail_q <= vec_q;
                        fail_valid_q <= 1'b1;
                    end
                    if (last_vec) begin
                        state_q   <= DONE;
                        gate_in_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= (err_d == '0);
                    end else begin
                        state_q   <= SETTLE;
                        vec_q     <= vec_q + ONE_VEC;
                        gate_in_q <= vec_q + ONE_VEC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gate_in        = gate_in_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb/tb_gate_truth_sequencer.sv - randomized scoreboard bench for gate_truth_sequencer
module tb_gate_truth_sequencer;

    typedef struct {
        int done_cyc;
        int err;
        int fv;
        int ffv;
        int pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst0, rst1;
    logic [3:0] tbl0;
    logic [7:0] tbl1;

    int checks = 0;
    int passes = 0;

    exp_t q0[$];
    exp_t q1[$];

    gate_truth_sequencer_if #(.N_IN(2)) bus0();
    gate_truth_sequencer_if #(.N_IN(3)) bus1();

    gate_truth_sequencer #(.N_IN(2), .EXPECTED(4'b1110), .SETTLE_CYC(2)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave)
    );
    gate_truth_sequencer #(.N_IN(3), .EXPECTED(8'hFE), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave)
    );

    // Gate under test: a lookup table the bench can rewire per run
    assign bus0.gate_out = tbl0[bus0.gate_in];
    assign bus1.gate_out = tbl1[bus1.gate_in];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int rd_gate_in(input int w);
        return (w == 0) ? int'(bus0.gate_in) : int'(bus1.gate_in);
    endfunction
    function automatic int rd_busy(input int w);
        return (w == 0) ? int'(bus0.busy) : int'(bus1.busy);
    endfunction
    function automatic int rd_done(input int w);
        return (w == 0) ? int'(bus0.done) : int'(bus1.done);
    endfunction
    function automatic int rd_pass(input int w);
        return (w == 0) ? int'(bus0.pass) : int'(bus1.pass);
    endfunction
    function automatic int rd_err(input int w);
        return (w == 0) ? int'(bus0.err_count) : int'(bus1.err_count);
    endfunction
    function automatic int rd_fv(input int w);
        return (w == 0) ? int'(bus0.fail_valid) : int'(bus1.fail_valid);
    endfunction
    function automatic int rd_ffv(input int w);
        return (w == 0) ? int'(bus0.first_fail_vec) : int'(bus1.first_fail_vec);
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) bus0.start = v; else bus1.start = v;
    endtask
    task automatic set_rst(input int w, input logic v);
        if (w == 0) rst0 = v; else rst1 = v;
    endtask

    // Reference: compare the wired gate's table with the expected one, vector by vector
    function automatic exp_t model(input int n, input logic [63:0] etbl,
                                   input logic [63:0] gtbl, input int settle, input int k);
        exp_t m;
        m.err = 0; m.fv = 0; m.ffv = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gtbl[v] !== etbl[v]) begin
                m.err++;
                if (m.fv == 0) begin m.fv = 1; m.ffv = v; end
            end
        end
        m.pass = (m.err == 0) ? 1 : 0;
        m.done_cyc = k + (1 << n) * (settle + 1);
        return m;
    endfunction

    task automatic check_idle(input int w, input string tag);
        check($sformatf("%s dut%0d outputs after reset", tag, w),
              rd_gate_in(w) | rd_busy(w) | rd_done(w) | rd_pass(w) | rd_err(w) | rd_fv(w) | rd_ffv(w), 0);
    endtask

    task automatic score(input int w, input exp_t e);
        check($sformatf("dut%0d done cycle", w), cyc, e.done_cyc);
        check($sformatf("dut%0d err_count", w), rd_err(w), e.err);
        check($sformatf("dut%0d fail_valid", w), rd_fv(w), e.fv);
        if (e.fv != 0) check($sformatf("dut%0d first_fail_vec", w), rd_ffv(w), e.ffv);
        check($sformatf("dut%0d pass", w), rd_pass(w), e.pass);
        check($sformatf("dut%0d idle at done", w), rd_busy(w) | rd_gate_in(w), 0);
    endtask

    logic done0_prev = 1'b0;
    logic done1_prev = 1'b0;

    // Monitors: on each rising done, pop the oldest expectation and compare
    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.done && !done0_prev) begin
            if (q0.size() == 0) check("dut0 unexpected done", 1, 0);
            else begin e = q0.pop_front(); score(0, e); end
        end
        done0_prev = bus0.done;
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.done && !done1_prev) begin
            if (q1.size() == 0) check("dut1 unexpected done", 1, 0);
            else begin e = q1.pop_front(); score(1, e); end
        end
        done1_prev = bus1.done;
    end

    task automatic run(input int w, input logic [63:0] gtbl, input int poke_j);
        int n, settle, total, k, bad, t;
        logic [63:0] etbl;
        n      = (w == 0) ? 2 : 3;
        settle = (w == 0) ? 2 : 1;
        etbl   = (w == 0) ? 64'hE : 64'hFE;
        total  = (1 << n) * (settle + 1);
        if (w == 0) tbl0 = gtbl[3:0]; else tbl1 = gtbl[7:0];
        @(negedge clk); set_start(w, 1'b1);
        @(negedge clk); set_start(w, 1'b0);
        k = cyc;
        if (w == 0) q0.push_back(model(n, etbl, gtbl, settle, k));
        else        q1.push_back(model(n, etbl, gtbl, settle, k));
        check($sformatf("dut%0d busy after accept", w), rd_busy(w), 1);
        check($sformatf("dut%0d results cleared on accept", w),
              rd_done(w) | rd_pass(w) | rd_err(w) | rd_fv(w), 0);
        bad = 0;
        for (int j = 0; j < total; j++) begin
            if (j > 0) @(negedge clk);
            if (j == poke_j) set_start(w, 1'b1);
            else if (j == poke_j + 1) set_start(w, 1'b0);
            if (rd_gate_in(w) != j / (settle + 1) || rd_busy(w) != 1) bad++;
        end
        set_start(w, 1'b0);
        check($sformatf("dut%0d gate_in sequence bad cycles", w), bad, 0);
        t = 0;
        while (rd_done(w) == 0 && t < 8) begin @(negedge clk); t++; end
        check($sformatf("dut%0d done within bound", w), rd_done(w), 1);
    endtask

    task automatic abort_run(input int w);
        if (w == 0) tbl0 = 4'hE; else tbl1 = 8'hFE;
        @(negedge clk); set_start(w, 1'b1);
        @(negedge clk); set_start(w, 1'b0);
        repeat (4) @(negedge clk);
        set_rst(w, 1'b1);
        set_start(w, 1'b1);
        @(negedge clk);
        check_idle(w, "mid-run");
        set_rst(w, 1'b0);
        set_start(w, 1'b0);
        @(negedge clk);
        check_idle(w, "post-abort");
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        tbl0 = 4'hE; tbl1 = 8'hFE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle(0, "initial");
        check_idle(1, "initial");
        rst0 = 1'b0; rst1 = 1'b0;

        run(0, 64'hE, -1);
        run(0, 64'h8, -1);
        run(0, 64'hF, -1);
        run(0, 64'h0, -1);
        abort_run(0);
        run(0, 64'hE, -1);
        run(0, 64'hE, 4);
        run(0, 64'h8, -1);
        run(1, 64'hFE, -1);
        run(1, 64'hFF, 3);
        abort_run(1);
        run(1, 64'h80, -1);

        for (int i = 0; i < 12; i++) begin
            int w, poke;
            logic [63:0] g;
            w = int'($urandom_range(0, 1));
            g = {$urandom, $urandom};
            poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : -1;
            run(w, g, poke);
        end

        repeat (3) @(negedge clk);
        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
